instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter INSTR_BYTES, default 4, bytes per instruction word.
REQ-002 SHALL have port ph1  input  1  clock; all state updates on posedge ph1.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  fetch request, sampled only in IDLE.
REQ-005 SHALL have port pc_in  input  8  base byte address of the instruction.
REQ-006 SHALL have port MemData  input  8  registered read data from the byte memory.
REQ-007 SHALL have port ack  input  1  consumer accepts instr, sampled only in DONE.
REQ-008 SHALL have port MemRead  output  1  memory read strobe.
REQ-009 SHALL have port Address  output  8  memory byte address.
REQ-010 SHALL have port instr  output  32  assembled instruction word.
REQ-011 SHALL have port valid  output  1  instr is complete and held.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port pc_next  output  8  base + INSTR_BYTES, modulo 256.

Function
REQ-014 SHALL implement states IDLE, ISSUE, DRAIN and DONE.
REQ-015 IDLE with start=1 at posedge SHALL latch base=pc_in, clear instr, set issue_cnt=0 and go to ISSUE.
REQ-016 ISSUE SHALL drive MemRead=1 and Address=base+issue_cnt (8-bit wrap) and increment issue_cnt each cycle.
REQ-017 After issuing issue_cnt=3, ISSUE SHALL go to DRAIN.
REQ-018 Memory read latency is one cycle, so the byte addressed in cycle n SHALL be captured from MemData at the end of cycle n+1.
REQ-019 Capture SHALL be little-endian: byte k goes to instr[8k+7:8k].
REQ-020 DRAIN SHALL drive MemRead=0 and Address=0, capture byte 3, set valid=1 and go to DONE.
REQ-021 valid SHALL rise on the 5th posedge after the start-accept edge, giving 4 memory cycles plus 1 drain cycle.
REQ-022 DONE SHALL hold instr, valid and pc_next stable until ack=1 at posedge, then go to IDLE with valid=0.
REQ-023 instr SHALL remain readable in IDLE after ack.
REQ-024 start outside IDLE SHALL be ignored; start with ack in DONE SHALL NOT begin a fetch.
REQ-025 ack outside DONE SHALL be ignored.
REQ-026 pc_in changes after the accept edge SHALL NOT affect an in-flight fetch.
REQ-027 Address wrap SHALL apply: base 8'hFE fetches FE, FF, 00, 01, and pc_next=8'h02.
REQ-028 MemRead SHALL be 0 in IDLE, DRAIN and DONE.
REQ-029 MemWrite is never driven by this block.

Reset
REQ-030 Synchronous reset SHALL force the state to IDLE.
REQ-031 Synchronous reset SHALL set instr=0, valid=0, busy=0, MemRead=0, Address=0, pc_next=0, base=0 and issue_cnt=0.
REQ-032 Reset mid-fetch SHALL abandon the fetch with no partial valid.
REQ-033 After reset, the first start SHALL be accepted on the first posedge where reset=0 and start=1.
REQ-034 Reset SHALL take priority over start and ack.

Structure
REQ-035 A shared package SHALL hold the fetch-state enum (IDLE/ISSUE/DRAIN/DONE), INSTR_BYTES and ADDR_W=8.
REQ-036 The block SHALL be a single module with no sub-module.
REQ-037 The byte counter and capture index SHALL be internal 2-bit registers.
REQ-038 Outputs SHALL be registered or decoded from the state only, with no combinational path from MemData to valid.

Verification
REQ-039 Memory preloaded 10:AA, 11:BB, 12:CC, 13:DD; start with pc_in=8'h10 -> Address sequence 10, 11, 12, 13 with MemRead=1; valid on the 5th edge; instr=32'hDDCCBBAA; pc_next=8'h14.
REQ-040 pc_in=8'hFE with FE:01, FF:02, 00:03, 01:04 -> addresses FE, FF, 00, 01; instr=32'h04030201; pc_next=8'h02.
REQ-041 Hold ack=0 for 10 cycles in DONE and pulse start -> instr and valid stable, no new MemRead; ack=1 -> IDLE, valid=0 next edge.
REQ-042 Assert reset after the 2nd ISSUE cycle -> next edge state IDLE with all outputs 0; then start with pc_in=8'h20 -> clean fetch of 20..23.
REQ-043 Back-to-back fetches: ack then start one cycle later with pc_in=pc_next -> second fetch addresses 14..17; no byte carries over from the first word.
REQ-044 Toggle pc_in during ISSUE -> addresses remain base-relative to the latched value.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the byte-serial instruction fetch unit.
// Holds the fetch FSM encoding and the byte-lane insert helper used by the datapath.
package instr_fetch_unit_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned WORD_W      = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } fetch_state_e;

  // Little-endian placement: byte idx lands in word[8*idx +: 8].
  function automatic logic [WORD_W-1:0] insert_byte(
    input logic [WORD_W-1:0] word,
    input logic [IDX_W-1:0]  idx,
    input logic [7:0]        data
  );
    logic [WORD_W-1:0] res;
    res = word;
    res[{idx, 3'b000} +: 8] = data;
    return res;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetches one little-endian instruction word from a byte memory with one-cycle read latency.
// Issues four byte reads, drains the last return, then holds the word until acknowledged.
module instr_fetch_unit #(
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  pc_in,
  input  logic [7:0]  MemData,
  input  logic        ack,
  output logic        MemRead,
  output logic [7:0]  Address,
  output logic [31:0] instr,
  output logic        valid,
  output logic        busy,
  output logic [7:0]  pc_next
);
  import instr_fetch_unit_pkg::*;

  localparam logic [ADDR_W-1:0] StepBytes = ADDR_W'(INSTR_BYTES);
  localparam logic [IDX_W-1:0]  LastIdx   = IDX_W'(INSTR_BYTES - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] pc_next_q;
  logic [IDX_W-1:0]  issue_cnt_q;
  logic [IDX_W-1:0]  cap_idx_q;
  logic [WORD_W-1:0] instr_q;

  // State register
  always_ff @(posedge ph1) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: if (issue_cnt_q == LastIdx) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  if (ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode: depends only on state and registered counters, never on MemData.
  always_comb begin
    MemRead = 1'b0;
    Address = '0;
    busy    = 1'b1;
    valid   = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
      end
      StIssue: begin
        MemRead = 1'b1;
        Address = base_q + {{(ADDR_W - IDX_W){1'b0}}, issue_cnt_q};
      end
      StDrain: begin
        MemRead = 1'b0;
      end
      StDone: begin
        valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Datapath: the byte issued in one ISSUE cycle returns on MemData in the following cycle,
  // so capture trails issue by one cycle and the final byte lands during DRAIN.
  always_ff @(posedge ph1) begin
    if (reset) begin
      base_q      <= '0;
      pc_next_q   <= '0;
      issue_cnt_q <= '0;
      cap_idx_q   <= '0;
      instr_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_q      <= pc_in;
            pc_next_q   <= pc_in + StepBytes;
            issue_cnt_q <= '0;
            cap_idx_q   <= '0;
            instr_q     <= '0;
          end
        end
        StIssue: begin
          issue_cnt_q <= issue_cnt_q + 1'b1;
          if (issue_cnt_q != '0) begin
            instr_q   <= insert_byte(instr_q, cap_idx_q, MemData);
            cap_idx_q <= cap_idx_q + 1'b1;
          end
        end
        StDrain: begin
          instr_q   <= insert_byte(instr_q, cap_idx_q, MemData);
          cap_idx_q <= cap_idx_q + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign instr   = instr_q;
  assign pc_next = pc_next_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus queues expected addresses and words,
// a negedge monitor pops and compares whenever MemRead or a valid rising edge appears.
module tb_instr_fetch_unit;

  logic        ph1;
  logic        reset;
  logic        start;
  logic [7:0]  pc_in;
  logic [7:0]  MemData;
  logic        ack;
  logic        MemRead;
  logic [7:0]  Address;
  logic [31:0] instr;
  logic        valid;
  logic        busy;
  logic [7:0]  pc_next;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc_next;
    int          cyc;
  } res_t;

  logic [7:0] addr_q[$];
  res_t       res_q[$];
  logic [7:0] mem[256];
  logic       valid_prev = 1'b0;

  instr_fetch_unit #(.INSTR_BYTES(4)) dut (
    .ph1     (ph1),
    .reset   (reset),
    .start   (start),
    .pc_in   (pc_in),
    .MemData (MemData),
    .ack     (ack),
    .MemRead (MemRead),
    .Address (Address),
    .instr   (instr),
    .valid   (valid),
    .busy    (busy),
    .pc_next (pc_next)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  always @(posedge ph1) cyc <= cyc + 1;

  // Registered byte memory: one-cycle read latency.
  always @(posedge ph1) begin
    if (MemRead === 1'b1) MemData <= mem[Address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge ph1) begin
    logic [7:0] exp_a;
    res_t       r;
    if (MemRead === 1'b1) begin
      if (addr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got MemRead=1 Address=%h required MemRead=0", Address);
      end else begin
        exp_a = addr_q.pop_front();
        check("address", {24'h0, Address}, {24'h0, exp_a});
      end
    end
    if (valid === 1'b1 && !valid_prev) begin
      if (res_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got valid=1 instr=%h required valid=0", instr);
      end else begin
        r = res_q.pop_front();
        check("instr", instr, r.instr);
        check("pc_next", {24'h0, pc_next}, {24'h0, r.pc_next});
        check("valid_edge", cyc, r.cyc);
      end
    end
    valid_prev = (valid === 1'b1);
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},   {31'h0, valid},   32'h0);
    check({tag, "_busy"},    {31'h0, busy},    32'h0);
    check({tag, "_memread"}, {31'h0, MemRead}, 32'h0);
    check({tag, "_address"}, {24'h0, Address}, 32'h0);
    check({tag, "_instr"},   instr,            32'h0);
    check({tag, "_pc_next"}, {24'h0, pc_next}, 32'h0);
  endtask

  // Called on a negedge; returns on the negedge where valid is first seen.
  task automatic do_fetch(input logic [7:0] pc, input logic [31:0] exp_i,
                          input logic [7:0] exp_n, input bit scramble);
    res_t r;
    int   n;
    start = 1'b1;
    pc_in = pc;
    for (int i = 0; i < 4; i++) addr_q.push_back(8'(pc + 8'(i)));
    @(posedge ph1);
    #1;
    r.instr   = exp_i;
    r.pc_next = exp_n;
    r.cyc     = cyc + 5;
    res_q.push_back(r);
    check("accept_busy", {31'h0, busy}, 32'h1);
    check("accept_instr_clear", instr, 32'h0);
    @(negedge ph1);
    start = 1'b0;
    n = 0;
    while (valid !== 1'b1 && n < 12) begin
      if (scramble) pc_in = 8'($urandom);
      @(negedge ph1);
      n++;
    end
    check("valid_seen", {31'h0, valid}, 32'h1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge ph1);
    ack = 1'b0;
    check("ack_idle", {31'h0, busy}, 32'h0);
    check("ack_valid_low", {31'h0, valid}, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ack   = 1'b0;
    pc_in = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;
    mem[8'h14] = 8'h11; mem[8'h15] = 8'h22; mem[8'h16] = 8'h33; mem[8'h17] = 8'h44;
    mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02; mem[8'h00] = 8'h03; mem[8'h01] = 8'h04;
    mem[8'h20] = 8'h5A; mem[8'h21] = 8'h6B; mem[8'h22] = 8'h7C; mem[8'h23] = 8'h8D;

    repeat (3) @(negedge ph1);
    check_all_zero("reset");
    reset = 1'b0;

    // Base fetch with pc_in toggling while in flight.
    do_fetch(8'h10, 32'hDDCCBBAA, 8'h14, 1'b1);

    // Hold in DONE with ack low; a start pulse must not begin a new fetch.
    for (int i = 0; i < 10; i++) begin
      @(negedge ph1);
      check("hold_valid", {31'h0, valid}, 32'h1);
      check("hold_instr", instr, 32'hDDCCBBAA);
      check("hold_pc_next", {24'h0, pc_next}, 32'h14);
      start = (i == 4);
      pc_in = 8'h40;
    end

    // ack together with start: leaves DONE, no fetch launched on that edge.
    ack   = 1'b1;
    start = 1'b1;
    @(negedge ph1);
    ack = 1'b0;
    check("ack_busy", {31'h0, busy}, 32'h0);
    check("ack_valid", {31'h0, valid}, 32'h0);
    check("idle_instr_kept", instr, 32'hDDCCBBAA);

    // Back-to-back fetch one cycle after ack, from pc_next.
    do_fetch(8'h14, 32'h44332211, 8'h18, 1'b0);
    do_ack();

    // Address wrap.
    do_fetch(8'hFE, 32'h04030201, 8'h02, 1'b0);
    do_ack();

    // Reset after two ISSUE cycles abandons the fetch.
    start = 1'b1;
    pc_in = 8'h20;
    addr_q.push_back(8'h20);
    addr_q.push_back(8'h21);
    @(negedge ph1);
    start = 1'b0;
    @(negedge ph1);
    reset = 1'b1;
    @(negedge ph1);
    check_all_zero("midreset");
    reset = 1'b0;

    do_fetch(8'h20, 32'h8D7C6B5A, 8'h24, 1'b0);
    do_ack();

    repeat (3) @(negedge ph1);
    check("addr_queue_empty", addr_q.size(), 32'h0);
    check("res_queue_empty", res_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin
    #50000;
    bad++;
    $display("FAIL timeout: got no completion required completion within 50000 time units");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
